mem_stage_sramlike: RTL and testbench

- Next-generation MEM pipeline stage for the LoongArch five-stage CPU, sitting between EXE and WB.
- Talks to a split-transaction (addr_ok/data_ok) data SRAM: EXE issues the request; this block waits for data_ok, aligns and extends the load data, and buffers it if WB stalls.
- Discards responses belonging to instructions flushed by exceptions or ERTN.
- Parametrised in data width and in outstanding-cancel depth.

---
 rtl/mem_stage_sramlike.sv | 163 ++++++++++++++++
 tb/tb_mem_stage_sramlike.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sramlike.sv
// MEM stage: waits on split-transaction SRAM data_ok, aligns/extends loads, buffers one response under WB stall.
// Latency: 0 cycles once data is available; holds while WB stalls; cancel counter drops responses for flushed requests.
module mem_stage_sramlike #(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 32,
    parameter int CANCEL_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exe_to_mem_valid,
    output logic              mem_allowin,
    input  logic [PC_W-1:0]   exe_pc,
    input  logic [DATA_W-1:0] exe_result,
    input  logic [4:0]        exe_dest,
    input  logic              exe_gr_we,
    input  logic              exe_load,
    input  logic              exe_mem_req,
    input  logic [1:0]        exe_ld_size,
    input  logic              exe_ld_signed,
    input  logic              exe_ex,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata,
    input  logic              flush,
    input  logic              wb_allowin,
    output logic              mem_to_wb_valid,
    output logic [PC_W-1:0]   mem_pc,
    output logic [DATA_W-1:0] mem_result,
    output logic [4:0]        mem_dest,
    output logic              mem_gr_we,
    output logic              mem_ex,
    output logic              mem_has_ex,
    output logic              fwd_we,
    output logic [4:0]        fwd_dest,
    output logic [DATA_W-1:0] fwd_data,
    output logic              fwd_stall
);

    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam logic [CANCEL_W-1:0] CNT_MAX = '1;
    localparam logic [CANCEL_W:0]   CNT_ONE = {{CANCEL_W{1'b0}}, 1'b1};

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] result;
        logic [4:0]        dest;
        logic              gr_we;
        logic              load;
        logic [1:0]        ld_size;
        logic              ld_signed;
        logic              ex;
    } mem_inst_t;

    mem_inst_t             exe_inst;
    mem_inst_t             inst_q;
    logic                  mem_valid;
    logic                  pend;
    logic                  buf_valid;
    logic [DATA_W-1:0]     buf_data;
    logic [CANCEL_W-1:0]   cancel_cnt;
    logic [CANCEL_W-1:0]   cancel_next;
    logic [CANCEL_W:0]     cnt_sum;

    logic                  data_ok_mine;
    logic                  drop_rsp;
    logic                  ready_go;
    logic                  capture;
    logic [DATA_W-1:0]     ld_src;
    logic [DATA_W-1:0]     shifted;
    logic [DATA_W-1:0]     aligned;
    logic                  sign_bit;
    int                    ext_w;

    assign exe_inst = '{pc: exe_pc, result: exe_result, dest: exe_dest, gr_we: exe_gr_we,
                        load: exe_load, ld_size: exe_ld_size, ld_signed: exe_ld_signed, ex: exe_ex};

    // A response is ours only once every cancelled request ahead of it has drained.
    assign data_ok_mine = pend && data_sram_data_ok && (cancel_cnt == '0);
    assign drop_rsp     = data_sram_data_ok && (cancel_cnt != '0);

    assign ready_go    = !pend || data_ok_mine || buf_valid;
    assign mem_allowin = !reset && (!mem_valid || (ready_go && wb_allowin));
    assign capture     = exe_to_mem_valid && mem_allowin && !flush;

    always_comb begin
        cnt_sum = {1'b0, cancel_cnt};
        if (flush) begin
            if (pend && !data_ok_mine)
                cnt_sum = cnt_sum + CNT_ONE;
            if (exe_to_mem_valid && exe_mem_req)
                cnt_sum = cnt_sum + CNT_ONE;
        end
        if (drop_rsp)
            cnt_sum = cnt_sum - CNT_ONE;
        cancel_next = (cnt_sum > {1'b0, CNT_MAX}) ? CNT_MAX : cnt_sum[CANCEL_W-1:0];
    end

    assign ld_src  = buf_valid ? buf_data : data_sram_rdata;
    assign shifted = ld_src >> {inst_q.result[OFF_W-1:0], 3'b000};

    always_comb begin
        ext_w    = DATA_W;
        sign_bit = shifted[DATA_W-1];
        case (inst_q.ld_size)
            2'd0: begin ext_w = 8;  sign_bit = shifted[7];  end
            2'd1: begin ext_w = 16; sign_bit = shifted[15]; end
            2'd2: begin ext_w = 32; sign_bit = shifted[31]; end
            default: begin ext_w = DATA_W; sign_bit = shifted[DATA_W-1]; end
        endcase
        aligned = '0;
        for (int i = 0; i < DATA_W; i++)
            aligned[i] = (i < ext_w) ? shifted[i] : (inst_q.ld_signed & sign_bit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid  <= 1'b0;
            pend       <= 1'b0;
            buf_valid  <= 1'b0;
            buf_data   <= '0;
            cancel_cnt <= '0;
            inst_q     <= '0;
        end else begin
            if (flush)
                mem_valid <= 1'b0;
            else if (mem_allowin)
                mem_valid <= exe_to_mem_valid;

            if (capture)
                inst_q <= exe_inst;

            if (flush)
                pend <= 1'b0;
            else if (capture)
                pend <= exe_mem_req;
            else if (data_ok_mine)
                pend <= 1'b0;

            // Only reachable while WB stalls: with wb_allowin the data passes straight through.
            if (flush || mem_allowin)
                buf_valid <= 1'b0;
            else if (data_ok_mine)
                buf_valid <= 1'b1;

            if (data_ok_mine)
                buf_data <= data_sram_rdata;

            cancel_cnt <= cancel_next;
        end
    end

    assign mem_to_wb_valid = mem_valid && ready_go && !flush;
    assign mem_pc          = inst_q.pc;
    assign mem_result      = inst_q.load ? aligned : inst_q.result;
    assign mem_dest        = inst_q.dest;
    assign mem_gr_we       = inst_q.gr_we && !inst_q.ex;
    assign mem_ex          = inst_q.ex;
    assign mem_has_ex      = mem_valid && inst_q.ex;
    assign fwd_we          = mem_valid && mem_gr_we;
    assign fwd_dest        = inst_q.dest;
    assign fwd_data        = mem_result;
    assign fwd_stall       = mem_valid && inst_q.load && pend && !data_ok_mine;

endmodule

// File: tb/tb_mem_stage_sramlike.sv
// Directed bench for mem_stage_sramlike: 32-bit instance for the main paths, 64-bit instance for doubleword loads.
module tb_mem_stage_sramlike;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        exe_to_mem_valid;
    logic        mem_allowin;
    logic [31:0] exe_pc;
    logic [31:0] exe_result;
    logic [4:0]  exe_dest;
    logic        exe_gr_we;
    logic        exe_load;
    logic        exe_mem_req;
    logic [1:0]  exe_ld_size;
    logic        exe_ld_signed;
    logic        exe_ex;
    logic        data_ok;
    logic [31:0] rdata;
    logic        flush;
    logic        wb_allowin;
    logic        mem_to_wb_valid;
    logic [31:0] mem_pc;
    logic [31:0] mem_result;
    logic [4:0]  mem_dest;
    logic        mem_gr_we;
    logic        mem_ex;
    logic        mem_has_ex;
    logic        fwd_we;
    logic [4:0]  fwd_dest;
    logic [31:0] fwd_data;
    logic        fwd_stall;

    logic        d_exe_valid;
    logic [63:0] d_exe_result;
    logic [1:0]  d_size;
    logic        d_signed;
    logic        d_data_ok;
    logic [63:0] d_rdata;
    logic        d_mem_allowin;
    logic        d_wbv;
    logic [31:0] d_mem_pc;
    logic [63:0] d_mem_result;
    logic [4:0]  d_mem_dest;
    logic        d_mem_gr_we;
    logic        d_mem_ex;
    logic        d_mem_has_ex;
    logic        d_fwd_we;
    logic [4:0]  d_fwd_dest;
    logic [63:0] d_fwd_data;
    logic        d_fwd_stall;

    int total = 0;
    int bad   = 0;

    mem_stage_sramlike #(.DATA_W(32), .PC_W(32), .CANCEL_W(2)) u_dut (
        .clk(clk), .reset(reset),
        .exe_to_mem_valid(exe_to_mem_valid), .mem_allowin(mem_allowin),
        .exe_pc(exe_pc), .exe_result(exe_result), .exe_dest(exe_dest),
        .exe_gr_we(exe_gr_we), .exe_load(exe_load), .exe_mem_req(exe_mem_req),
        .exe_ld_size(exe_ld_size), .exe_ld_signed(exe_ld_signed), .exe_ex(exe_ex),
        .data_sram_data_ok(data_ok), .data_sram_rdata(rdata),
        .flush(flush), .wb_allowin(wb_allowin),
        .mem_to_wb_valid(mem_to_wb_valid), .mem_pc(mem_pc), .mem_result(mem_result),
        .mem_dest(mem_dest), .mem_gr_we(mem_gr_we), .mem_ex(mem_ex), .mem_has_ex(mem_has_ex),
        .fwd_we(fwd_we), .fwd_dest(fwd_dest), .fwd_data(fwd_data), .fwd_stall(fwd_stall)
    );

    mem_stage_sramlike #(.DATA_W(64), .PC_W(32), .CANCEL_W(2)) u_dut64 (
        .clk(clk), .reset(reset),
        .exe_to_mem_valid(d_exe_valid), .mem_allowin(d_mem_allowin),
        .exe_pc(32'h0), .exe_result(d_exe_result), .exe_dest(5'd1),
        .exe_gr_we(1'b1), .exe_load(1'b1), .exe_mem_req(d_exe_valid),
        .exe_ld_size(d_size), .exe_ld_signed(d_signed), .exe_ex(1'b0),
        .data_sram_data_ok(d_data_ok), .data_sram_rdata(d_rdata),
        .flush(1'b0), .wb_allowin(1'b1),
        .mem_to_wb_valid(d_wbv), .mem_pc(d_mem_pc), .mem_result(d_mem_result),
        .mem_dest(d_mem_dest), .mem_gr_we(d_mem_gr_we), .mem_ex(d_mem_ex), .mem_has_ex(d_mem_has_ex),
        .fwd_we(d_fwd_we), .fwd_dest(d_fwd_dest), .fwd_data(d_fwd_data), .fwd_stall(d_fwd_stall)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one instruction from EXE for a single cycle; MEM must be able to take it.
    task automatic issue(input logic [31:0] pc, input logic [31:0] res, input logic ld,
                         input logic req, input logic [1:0] size, input logic sgn,
                         input logic [4:0] dest, input logic ex);
        exe_to_mem_valid = 1'b1;
        exe_pc = pc; exe_result = res; exe_load = ld; exe_mem_req = req;
        exe_ld_size = size; exe_ld_signed = sgn; exe_dest = dest; exe_gr_we = 1'b1; exe_ex = ex;
        #1;
        chk("issue_allowin", mem_allowin, 1'b1);
        tick();
        exe_to_mem_valid = 1'b0; exe_mem_req = 1'b0; exe_load = 1'b0; exe_ex = 1'b0;
    endtask

    task automatic ld_check(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input logic sgn, input logic [31:0] rd, input logic [31:0] exp);
        issue(32'h1c000100, addr, 1'b1, 1'b1, size, sgn, 5'd7, 1'b0);
        data_ok = 1'b1; rdata = rd;
        #1;
        chk(tag, mem_result, exp);
        tick();
        data_ok = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; wb_allowin = 1'b1; data_ok = 1'b0; rdata = '0;
        exe_to_mem_valid = 1'b0; exe_pc = '0; exe_result = '0; exe_dest = '0; exe_gr_we = 1'b0;
        exe_load = 1'b0; exe_mem_req = 1'b0; exe_ld_size = '0; exe_ld_signed = 1'b0; exe_ex = 1'b0;
        d_exe_valid = 1'b0; d_exe_result = '0; d_size = '0; d_signed = 1'b0; d_data_ok = 1'b0; d_rdata = '0;
        tick(); tick();
        chk("rst_allowin", mem_allowin, 1'b0);
        chk("rst_wbv", mem_to_wb_valid, 1'b0);
        chk("rst_result", mem_result, 32'h0);
        chk("rst_stall", fwd_stall, 1'b0);
        chk("rst_fwd_we", fwd_we, 1'b0);
        chk("rst_has_ex", mem_has_ex, 1'b0);
        chk("rst_cancel", u_dut.cancel_cnt, 2'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_allowin", mem_allowin, 1'b1);

        // ld.w, response three cycles after MEM takes it
        issue(32'h1c000000, 32'h1000, 1'b1, 1'b1, 2'd2, 1'b0, 5'd5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ldw_stall", fwd_stall, 1'b1);
            chk("ldw_wait_wbv", mem_to_wb_valid, 1'b0);
            tick();
        end
        data_ok = 1'b1; rdata = 32'hDEADBEEF;
        #1;
        chk("ldw_wbv", mem_to_wb_valid, 1'b1);
        chk("ldw_result", mem_result, 32'hDEADBEEF);
        chk("ldw_stall_off", fwd_stall, 1'b0);
        chk("ldw_pc", mem_pc, 32'h1c000000);
        chk("ldw_dest", mem_dest, 5'd5);
        chk("ldw_fwd_data", fwd_data, 32'hDEADBEEF);
        tick();
        data_ok = 1'b0;
        #1;
        chk("ldw_gone", mem_to_wb_valid, 1'b0);

        ld_check("ldb_sx_off3", 32'h2003, 2'd0, 1'b1, 32'h80123456, 32'hFFFFFF80);
        ld_check("ldhu_off2",   32'h2002, 2'd1, 1'b0, 32'hABCD1234, 32'h0000ABCD);
        ld_check("ldh_sx_off0", 32'h2000, 2'd1, 1'b1, 32'h12348001, 32'hFFFF8001);
        ld_check("ldbu_off1",   32'h2001, 2'd0, 1'b0, 32'h0000F100, 32'h000000F1);
        ld_check("ldw_sx",      32'h2004, 2'd2, 1'b1, 32'h87654321, 32'h87654321);

        // response lands while WB is stalled
        issue(32'h1c000200, 32'h3000, 1'b1, 1'b1, 2'd2, 1'b0, 5'd8, 1'b0);
        wb_allowin = 1'b0; data_ok = 1'b1; rdata = 32'h55;
        #1;
        chk("buf_wbv_first", mem_to_wb_valid, 1'b1);
        chk("buf_allowin_first", mem_allowin, 1'b0);
        tick();
        data_ok = 1'b0; rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("buf_hold_result", mem_result, 32'h55);
            chk("buf_hold_wbv", mem_to_wb_valid, 1'b1);
            tick();
        end
        wb_allowin = 1'b1;
        #1;
        chk("buf_release_allowin", mem_allowin, 1'b1);
        tick();
        #1;
        chk("buf_single_xfer", mem_to_wb_valid, 1'b0);

        // flush with MEM waiting and EXE handing over another accepted request
        issue(32'h1c000300, 32'h4000, 1'b1, 1'b1, 2'd2, 1'b0, 5'd9, 1'b0);
        flush = 1'b1; exe_to_mem_valid = 1'b1; exe_mem_req = 1'b1; exe_load = 1'b1; exe_result = 32'h4100;
        #1;
        chk("flush_wbv", mem_to_wb_valid, 1'b0);
        tick();
        flush = 1'b0; exe_to_mem_valid = 1'b0; exe_mem_req = 1'b0; exe_load = 1'b0;
        #1;
        chk("cancel_two", u_dut.cancel_cnt, 2'd2);
        chk("flush_valid_gone", mem_to_wb_valid, 1'b0);
        issue(32'h1c000400, 32'h5000, 1'b1, 1'b1, 2'd2, 1'b0, 5'd10, 1'b0);
        data_ok = 1'b1; rdata = 32'h111;
        #1;
        chk("drop1_wbv", mem_to_wb_valid, 1'b0);
        chk("drop1_stall", fwd_stall, 1'b1);
        tick();
        rdata = 32'h222;
        #1;
        chk("drop2_wbv", mem_to_wb_valid, 1'b0);
        chk("drop2_cancel", u_dut.cancel_cnt, 2'd1);
        tick();
        rdata = 32'h333;
        #1;
        chk("accept_wbv", mem_to_wb_valid, 1'b1);
        chk("accept_result", mem_result, 32'h333);
        chk("accept_cancel", u_dut.cancel_cnt, 2'd0);
        tick();
        data_ok = 1'b0;

        // flush coinciding with our own response
        issue(32'h1c000500, 32'h6000, 1'b1, 1'b1, 2'd2, 1'b0, 5'd11, 1'b0);
        flush = 1'b1; data_ok = 1'b1; rdata = 32'h666;
        #1;
        chk("fd_wbv", mem_to_wb_valid, 1'b0);
        tick();
        flush = 1'b0; data_ok = 1'b0;
        #1;
        chk("fd_cancel", u_dut.cancel_cnt, 2'd0);
        chk("fd_wbv_after", mem_to_wb_valid, 1'b0);
        chk("fd_allowin", mem_allowin, 1'b1);

        // plain ALU result and its exception variant
        issue(32'h1c000600, 32'd7, 1'b0, 1'b0, 2'd0, 1'b0, 5'd4, 1'b0);
        #1;
        chk("add_wbv", mem_to_wb_valid, 1'b1);
        chk("add_fwd_we", fwd_we, 1'b1);
        chk("add_fwd_dest", fwd_dest, 5'd4);
        chk("add_fwd_data", fwd_data, 32'd7);
        chk("add_gr_we", mem_gr_we, 1'b1);
        chk("add_has_ex", mem_has_ex, 1'b0);
        tick();
        issue(32'h1c000604, 32'd9, 1'b0, 1'b0, 2'd0, 1'b0, 5'd6, 1'b1);
        #1;
        chk("ex_has_ex", mem_has_ex, 1'b1);
        chk("ex_gr_we", mem_gr_we, 1'b0);
        chk("ex_mem_ex", mem_ex, 1'b1);
        chk("ex_fwd_we", fwd_we, 1'b0);
        tick();

        // 64-bit instance: ld.d, ld.w signed at offset 4, ld.bu at offset 7
        d_exe_valid = 1'b1; d_exe_result = 64'h8000; d_size = 2'd3; d_signed = 1'b0;
        #1;
        chk("d64_allowin", d_mem_allowin, 1'b1);
        tick();
        d_exe_valid = 1'b0; d_data_ok = 1'b1; d_rdata = 64'h0123456789ABCDEF;
        #1;
        chk("d64_ldd_result", d_mem_result, 64'h0123456789ABCDEF);
        chk("d64_ldd_wbv", d_wbv, 1'b1);
        tick();
        d_data_ok = 1'b0;
        d_exe_valid = 1'b1; d_exe_result = 64'h8004; d_size = 2'd2; d_signed = 1'b1;
        tick();
        d_exe_valid = 1'b0; d_data_ok = 1'b1; d_rdata = 64'h80000000_12345678;
        #1;
        chk("d64_ldw_sx_off4", d_mem_result, 64'hFFFFFFFF_80000000);
        tick();
        d_data_ok = 1'b0;
        d_exe_valid = 1'b1; d_exe_result = 64'h8007; d_size = 2'd0; d_signed = 1'b0;
        tick();
        d_exe_valid = 1'b0; d_data_ok = 1'b1; d_rdata = 64'hAB00_0000_0000_00FF;
        #1;
        chk("d64_ldbu_off7", d_mem_result, 64'h00000000_000000AB);
        tick();
        d_data_ok = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
